// File: rtl/lbcnn_pkg.sv
// Shared types for the lbcnn datapath: pixel format, loader FSM states and
// frame geometry helper.
package lbcnn_pkg;

  typedef logic signed [15:0] pixel_t;

  typedef enum logic [1:0] {FILL, DRAIN, HOLD} loader_state_t;

  function automatic int frame_beats(input int n);
    return n * n;
  endfunction

endpackage

// File: rtl/pix_pos_counter.sv
// Row-major (row, col) position tracker for an IMG_SIZE x IMG_SIZE frame.
// Clear has priority over advance.
module pix_pos_counter #(
  parameter int IMG_SIZE = 15,
  parameter int RC_W     = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            advance,
  output logic [RC_W-1:0] row,
  output logic [RC_W-1:0] col,
  output logic            at_last
);

  localparam logic [RC_W-1:0] LAST = RC_W'(IMG_SIZE - 1);

  logic [RC_W-1:0] row_q, row_d;
  logic [RC_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + RC_W'(1);
      end else begin
        col_d = col_q + RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row     = row_q;
  assign col     = col_q;
  assign at_last = (row_q == LAST) && (col_q == LAST);

endmodule

// File: rtl/ifmap_loader.sv
// Stream-to-frame deserializer: fills a square ifmap row-major from a
// valid/ready pixel stream, checks length against s_last, and holds the frame
// until the consumer acks it.
module ifmap_loader
  import lbcnn_pkg::*;
#(
  parameter int IMG_SIZE = 15,
  parameter int FCNT_W   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  pixel_t                               s_data,
  input  logic                                 s_last,
  output pixel_t [IMG_SIZE-1:0][IMG_SIZE-1:0]  ifmap,
  output logic                                 frame_valid,
  input  logic                                 frame_ack,
  output logic                                 err_len,
  output logic [FCNT_W-1:0]                    frame_cnt
);

  localparam int RC_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

  loader_state_t state_q, state_d;
  pixel_t [IMG_SIZE-1:0][IMG_SIZE-1:0] ifmap_q, ifmap_d;
  logic              s_ready_q, s_ready_d;
  logic              frame_valid_q, frame_valid_d;
  logic              err_len_q, err_len_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic            pos_clr, pos_adv, at_last;
  logic [RC_W-1:0] row, col;
  logic            accept;

  assign accept = s_valid && s_ready_q;

  pix_pos_counter #(.IMG_SIZE(IMG_SIZE), .RC_W(RC_W)) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (pos_clr),
    .advance (pos_adv),
    .row     (row),
    .col     (col),
    .at_last (at_last)
  );

  always_comb begin
    state_d       = state_q;
    ifmap_d       = ifmap_q;
    frame_valid_d = frame_valid_q;
    err_len_d     = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    pos_clr       = 1'b0;
    pos_adv       = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          ifmap_d[row][col] = s_data;
          if (at_last) begin
            pos_clr = 1'b1;
            if (s_last) begin
              state_d       = HOLD;
              frame_valid_d = 1'b1;
              frame_cnt_d   = frame_cnt_q + FCNT_W'(1);
            end else begin
              // Over-long frame: keep what we have, swallow the tail.
              state_d   = DRAIN;
              err_len_d = 1'b1;
            end
          end else if (s_last) begin
            pos_clr   = 1'b1;
            err_len_d = 1'b1;
          end else begin
            pos_adv = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && s_last) begin
          state_d       = HOLD;
          frame_valid_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + FCNT_W'(1);
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_d       = FILL;
          frame_valid_d = 1'b0;
          pos_clr       = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
    // Ready depends only on the upcoming state, so it can be registered.
    s_ready_d = (state_d != HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      ifmap_q       <= '0;
      s_ready_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      err_len_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      ifmap_q       <= ifmap_d;
      s_ready_q     <= s_ready_d;
      frame_valid_q <= frame_valid_d;
      err_len_q     <= err_len_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign ifmap       = ifmap_q;
  assign frame_valid = frame_valid_q;
  assign err_len     = err_len_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_ifmap_loader.sv
// Directed bench for ifmap_loader: good/short/long frames, backpressure,
// async reset mid-frame and frame_ack corner cases.
module tb_ifmap_loader;
  import lbcnn_pkg::*;

  localparam int N     = 15;
  localparam int BEATS = frame_beats(N);

  logic clk = 1'b0;
  logic rst_n;
  logic s_valid, s_ready, s_last, frame_valid, frame_ack, err_len;
  pixel_t s_data;
  pixel_t [N-1:0][N-1:0] ifmap;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;

  ifmap_loader #(.IMG_SIZE(N), .FCNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .ifmap       (ifmap),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .err_len     (err_len),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err_len === 1'b1) err_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and wait (bounded) until it is accepted.
  task automatic send_beat(input pixel_t d, input logic last);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int k = 0; k < 50 && !done; k++) begin
      done = (s_ready === 1'b1);
      tick();
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send_beat_timeout: s_ready stuck at %b, required 1", s_ready);
    end
  endtask

  task automatic ack_frame();
    s_valid   = 1'b0;
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; frame_ack = 1'b0;
    #12;
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b required 0", frame_valid); end
    n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err_len); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d required 0", frame_cnt); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_low: got %b required 0", s_ready); end
    n_checks++; if (ifmap[14][14] !== 16'sd0) begin n_fail++; $display("FAIL reset_ifmap: got %0d required 0", ifmap[14][14]); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_high: got %b required 1", s_ready); end
  endtask

  task automatic test_good_frame();
    int e0 = err_cnt;
    for (int i = 0; i < BEATS; i++) begin
      if (i == BEATS - 1) begin
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL good_fv_early: got %b required 0", frame_valid); end
      end
      send_beat(pixel_t'(i), i == BEATS - 1);
    end
    s_valid = 1'b0;
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL good_fv: got %b required 1", frame_valid); end
    n_checks++; if (ifmap[0][0] !== 16'sd0) begin n_fail++; $display("FAIL good_00: got %0d required 0", ifmap[0][0]); end
    n_checks++; if (ifmap[0][14] !== 16'sd14) begin n_fail++; $display("FAIL good_0_14: got %0d required 14", ifmap[0][14]); end
    n_checks++; if (ifmap[1][0] !== 16'sd15) begin n_fail++; $display("FAIL good_1_0: got %0d required 15", ifmap[1][0]); end
    n_checks++; if (ifmap[14][14] !== 16'sd224) begin n_fail++; $display("FAIL good_14_14: got %0d required 224", ifmap[14][14]); end
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL good_cnt: got %0d required 1", frame_cnt); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL good_rdy: got %b required 0", s_ready); end
    n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL good_err: got %0d pulses required 0", err_cnt - e0); end
  endtask

  task automatic test_backpressure();
    s_valid = 1'b1; s_data = 16'sd777; s_last = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_hold%0d: got %b required 0", k, s_ready); end
      n_checks++; if (ifmap[7][7] !== 16'sd112 || ifmap[14][14] !== 16'sd224) begin
        n_fail++; $display("FAIL bp_frozen%0d: got %0d/%0d required 112/224", k, ifmap[7][7], ifmap[14][14]);
      end
    end
    ack_frame();
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL bp_fv_drop: got %b required 0", frame_valid); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_back: got %b required 1", s_ready); end
    for (int i = 0; i < BEATS; i++) begin
      s_valid = 1'b0;
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      send_beat(pixel_t'(-i), i == BEATS - 1);
    end
    s_valid = 1'b0;
    n_checks++; if (ifmap[14][14] !== -16'sd224) begin n_fail++; $display("FAIL bp_14_14: got %0d required -224", ifmap[14][14]); end
    n_checks++; if (ifmap[0][1] !== -16'sd1) begin n_fail++; $display("FAIL bp_0_1: got %0d required -1", ifmap[0][1]); end
    n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_cnt: got %0d required 2", frame_cnt); end
    ack_frame();
  endtask

  task automatic test_short_frame();
    int e0 = err_cnt;
    for (int i = 0; i < 100; i++) send_beat(pixel_t'(i), i == 99);
    s_valid = 1'b0;
    n_checks++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL short_err_hi: got %b required 1", err_len); end
    tick();
    n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL short_err_lo: got %b required 0", err_len); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL short_fv: got %b required 0", frame_valid); end
    for (int i = 0; i < BEATS; i++) send_beat(pixel_t'(1000 + i), i == BEATS - 1);
    s_valid = 1'b0;
    n_checks++; if (ifmap[0][0] !== 16'sd1000) begin n_fail++; $display("FAIL short_00: got %0d required 1000", ifmap[0][0]); end
    n_checks++; if (ifmap[14][14] !== 16'sd1224) begin n_fail++; $display("FAIL short_14_14: got %0d required 1224", ifmap[14][14]); end
    n_checks++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL short_cnt: got %0d required 3", frame_cnt); end
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL short_pulses: got %0d required 1", err_cnt - e0); end
    ack_frame();
  endtask

  task automatic test_long_frame();
    int e0 = err_cnt;
    for (int i = 0; i < 230; i++) begin
      send_beat(pixel_t'(i), i == 229);
      if (i == 224) begin
        n_checks++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL long_err_hi: got %b required 1", err_len); end
      end
      if (i == 228) begin
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL long_fv_early: got %b required 0", frame_valid); end
      end
    end
    s_valid = 1'b0;
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL long_fv: got %b required 1", frame_valid); end
    n_checks++; if (ifmap[14][14] !== 16'sd224) begin n_fail++; $display("FAIL long_14_14: got %0d required 224", ifmap[14][14]); end
    n_checks++; if (ifmap[0][0] !== 16'sd0) begin n_fail++; $display("FAIL long_00: got %0d required 0", ifmap[0][0]); end
    n_checks++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL long_cnt: got %0d required 4", frame_cnt); end
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL long_pulses: got %0d required 1", err_cnt - e0); end
    ack_frame();
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 50; i++) send_beat(pixel_t'(500 + i), 1'b0);
    s_valid = 1'b1; s_data = 16'sd550;
    rst_n = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_rdy: got %b required 0", s_ready); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d required 0", frame_cnt); end
    n_checks++; if (ifmap[0][0] !== 16'sd0) begin n_fail++; $display("FAIL rmid_ifmap: got %0d required 0", ifmap[0][0]); end
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < BEATS; i++) send_beat(pixel_t'(300 + i), i == BEATS - 1);
    s_valid = 1'b0;
    n_checks++; if (ifmap[0][0] !== 16'sd300) begin n_fail++; $display("FAIL rmid_00: got %0d required 300", ifmap[0][0]); end
    n_checks++; if (ifmap[14][14] !== 16'sd524) begin n_fail++; $display("FAIL rmid_14_14: got %0d required 524", ifmap[14][14]); end
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL rmid_cnt1: got %0d required 1", frame_cnt); end
    ack_frame();
  endtask

  task automatic test_ack_corners();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    n_checks++; if (s_ready !== 1'b1 || frame_valid !== 1'b0 || frame_cnt !== 16'd1) begin
      n_fail++; $display("FAIL ack_fill_idle: got rdy=%b fv=%b cnt=%0d required 1/0/1", s_ready, frame_valid, frame_cnt);
    end
    for (int i = 0; i < BEATS; i++) begin
      if (i == 10) begin
        s_valid = 1'b0; frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
      end
      send_beat(pixel_t'(2000 + i), i == BEATS - 1);
    end
    s_valid = 1'b0;
    n_checks++; if (ifmap[0][10] !== 16'sd2010) begin n_fail++; $display("FAIL ack_fill_0_10: got %0d required 2010", ifmap[0][10]); end
    n_checks++; if (ifmap[14][14] !== 16'sd2224) begin n_fail++; $display("FAIL ack_fill_14_14: got %0d required 2224", ifmap[14][14]); end
    n_checks++; if (frame_valid !== 1'b1 || frame_cnt !== 16'd2) begin
      n_fail++; $display("FAIL ack_fill_frame: got fv=%b cnt=%0d required 1/2", frame_valid, frame_cnt);
    end
    s_valid = 1'b1; s_data = -16'sd5; s_last = 1'b0; frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    n_checks++; if (frame_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL ack_hold_release: got fv=%b rdy=%b required 0/1", frame_valid, s_ready);
    end
    n_checks++; if (ifmap[0][0] !== 16'sd2000) begin n_fail++; $display("FAIL ack_beat_not_taken: got %0d required 2000", ifmap[0][0]); end
    tick();
    s_valid = 1'b0;
    n_checks++; if (ifmap[0][0] !== -16'sd5) begin n_fail++; $display("FAIL ack_beat_next: got %0d required -5", ifmap[0][0]); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_ack_corners();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
